// File: rtl/alu_pkg.sv
// Shared definitions for the simple_alu slice: opcode encoding and the status flag bundle.
package alu_pkg;

    localparam int ALU_OP_WIDTH = 3;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logical shifter; shiftOut is the last bit pushed off the end, 0 for a zero shift.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               shiftRight,
    output logic [WIDTH-1:0]   shifted,
    output logic               shiftOut
);

    logic [WIDTH:0] leftWide;
    logic [WIDTH:0] rightWide;

    // One guard bit on each side catches the final shifted-out bit and stays 0 when amount is 0.
    assign leftWide  = {1'b0, value} << amount;
    assign rightWide = {value, 1'b0} >> amount;

    always_comb begin
        shifted  = leftWide[WIDTH-1:0];
        shiftOut = leftWide[WIDTH];
        if (shiftRight) begin
            shifted  = rightWide[WIDTH:1];
            shiftOut = rightWide[0];
        end
    end

endmodule

// File: rtl/simple_alu.sv
// Registered 4-bit ALU: combinational datapath for 8 ops feeding one result/flag register stage.
module simple_alu
    import alu_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int OP_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    operandA,
    input  logic [WIDTH-1:0]    operandB,
    input  logic [OP_WIDTH-1:0] aluOp,
    output logic [WIDTH-1:0]    result,
    output logic                carry,
    output logic                zero,
    output logic                negative,
    output logic                overflow
);

    localparam int SHAMT_W = $clog2(WIDTH);

    alu_op_t          op;
    logic [WIDTH:0]   sumWide;
    logic [WIDTH:0]   diffWide;
    logic [WIDTH-1:0] shiftedValue;
    logic             shiftOut;
    logic [WIDTH-1:0] nextResult;
    alu_flags_t       nextFlags;
    logic [WIDTH-1:0] resultReg;
    alu_flags_t       flagsReg;

    assign op       = alu_op_t'(aluOp);
    assign sumWide  = {1'b0, operandA} + {1'b0, operandB};
    assign diffWide = {1'b0, operandA} - {1'b0, operandB};

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) shifter (
        .value      (operandA),
        .amount     (operandB[SHAMT_W-1:0]),
        .shiftRight (op == OP_SHR),
        .shifted    (shiftedValue),
        .shiftOut   (shiftOut)
    );

    // The top bit of the widened difference doubles as the unsigned borrow.
    always_comb begin
        nextResult         = '0;
        nextFlags          = '0;
        case (op)
            OP_ADD: begin
                nextResult         = sumWide[WIDTH-1:0];
                nextFlags.carry    = sumWide[WIDTH];
                nextFlags.overflow = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                                     (sumWide[WIDTH-1] != operandA[WIDTH-1]);
            end
            OP_SUB: begin
                nextResult         = diffWide[WIDTH-1:0];
                nextFlags.carry    = diffWide[WIDTH];
                nextFlags.overflow = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                                     (diffWide[WIDTH-1] != operandA[WIDTH-1]);
            end
            OP_AND: nextResult = operandA & operandB;
            OP_OR:  nextResult = operandA | operandB;
            OP_XOR: nextResult = operandA ^ operandB;
            OP_NOT: nextResult = ~operandA;
            OP_SHL, OP_SHR: begin
                nextResult      = shiftedValue;
                nextFlags.carry = shiftOut;
            end
            default: nextResult = '0;
        endcase
        nextFlags.zero     = (nextResult == '0);
        nextFlags.negative = nextResult[WIDTH-1];
    end

    // Reset leaves a zero result, so zero is the only flag that comes up set.
    always_ff @(posedge clk) begin
        if (rst) begin
            resultReg <= '0;
            flagsReg  <= '{carry: 1'b0, zero: 1'b1, negative: 1'b0, overflow: 1'b0};
        end else begin
            resultReg <= nextResult;
            flagsReg  <= nextFlags;
        end
    end

    assign result   = resultReg;
    assign carry    = flagsReg.carry;
    assign zero     = flagsReg.zero;
    assign negative = flagsReg.negative;
    assign overflow = flagsReg.overflow;

endmodule

// File: tb/tb_simple_alu.sv
// Directed and randomized self-checking bench for simple_alu with an arithmetic reference model.
module tb_simple_alu;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] operandA = '0;
    logic [WIDTH-1:0] operandB = '0;
    logic [2:0]       aluOp = '0;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    simple_alu #(.WIDTH(WIDTH), .OP_WIDTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .operandA (operandA),
        .operandB (operandB),
        .aluOp    (aluOp),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge so the next rising edge samples them cleanly.
    task automatic applyStimulus(input int a, input int b, input int op, input logic r);
        @(negedge clk);
        operandA = WIDTH'(a);
        operandB = WIDTH'(b);
        aluOp    = 3'(op);
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input int expRes, input int expCarry,
                               input int expZero, input int expNeg, input int expOv);
        checkField({tag, ".result"},   int'(result),   expRes);
        checkField({tag, ".carry"},    int'(carry),    expCarry);
        checkField({tag, ".zero"},     int'(zero),     expZero);
        checkField({tag, ".negative"}, int'(negative), expNeg);
        checkField({tag, ".overflow"}, int'(overflow), expOv);
    endtask

    function automatic int toSigned(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Reference built from integer arithmetic and bit-at-a-time shifting.
    task automatic modelOp(input int a, input int b, input int op,
                           output int res, output int c, output int ov);
        int s;
        int amt;
        res = 0; c = 0; ov = 0;
        case (op)
            0: begin
                s   = a + b;
                res = s % 16;
                c   = (s > 15) ? 1 : 0;
                s   = toSigned(a) + toSigned(b);
                ov  = (s > 7 || s < -8) ? 1 : 0;
            end
            1: begin
                res = (a - b + 16) % 16;
                c   = (a < b) ? 1 : 0;
                s   = toSigned(a) - toSigned(b);
                ov  = (s > 7 || s < -8) ? 1 : 0;
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 15 - a;
            6: begin
                res = a;
                amt = b % 4;
                for (int i = 0; i < amt; i++) begin
                    c   = (res >= 8) ? 1 : 0;
                    res = (res * 2) % 16;
                end
            end
            default: begin
                res = a;
                amt = b % 4;
                for (int i = 0; i < amt; i++) begin
                    c   = res % 2;
                    res = res / 2;
                end
            end
        endcase
    endtask

    initial begin
        int a, b, op, r, res, c, ov;

        applyStimulus(15, 15, 0, 1'b1);
        checkOutput("reset1", 0, 0, 1, 0, 0);
        applyStimulus(15, 15, 0, 1'b1);
        checkOutput("reset2", 0, 0, 1, 0, 0);
        applyStimulus(15, 15, 0, 1'b0);
        checkOutput("addAfterReset", 14, 1, 0, 1, 0);

        applyStimulus(10, 0, 1, 1'b0);
        checkOutput("sub10m0", 10, 0, 0, 1, 0);
        applyStimulus(3, 5, 1, 1'b0);
        checkOutput("sub3m5", 14, 1, 0, 1, 0);

        applyStimulus(7, 1, 0, 1'b0);
        checkOutput("addOverflow", 8, 0, 0, 1, 1);
        applyStimulus(8, 1, 1, 1'b0);
        checkOutput("subOverflow", 7, 0, 0, 0, 1);
        applyStimulus(5, 5, 1, 1'b0);
        checkOutput("subZero", 0, 0, 1, 0, 0);

        applyStimulus(12, 10, 2, 1'b0);
        checkOutput("and", 8, 0, 0, 1, 0);
        applyStimulus(12, 10, 3, 1'b0);
        checkOutput("or", 14, 0, 0, 1, 0);
        applyStimulus(12, 10, 4, 1'b0);
        checkOutput("xor", 6, 0, 0, 0, 0);
        applyStimulus(12, 10, 5, 1'b0);
        checkOutput("not", 3, 0, 0, 0, 0);

        applyStimulus(9, 1, 6, 1'b0);
        checkOutput("shl1", 2, 1, 0, 0, 0);
        applyStimulus(9, 2, 7, 1'b0);
        checkOutput("shr2", 2, 0, 0, 0, 0);
        applyStimulus(9, 4, 6, 1'b0);
        checkOutput("shl0", 9, 0, 0, 1, 0);
        applyStimulus(9, 3, 7, 1'b0);
        checkOutput("shr3", 1, 0, 0, 0, 0);

        for (int i = 0; i < 5000; i++) begin
            a  = $urandom_range(15);
            b  = $urandom_range(15);
            op = $urandom_range(7);
            r  = (i == 2500) ? 1 : 0;
            applyStimulus(a, b, op, r[0]);
            if (r == 1) begin
                checkOutput("midReset", 0, 0, 1, 0, 0);
            end else begin
                modelOp(a, b, op, res, c, ov);
                checkOutput($sformatf("rand%0d_a%0d_b%0d_op%0d", i, a, b, op),
                            res, c, (res == 0) ? 1 : 0, (res >= 8) ? 1 : 0, ov);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
